// File: rtl/coherent_dcache_if.sv
// Processor-side request/response and coherence-bus signals of one L1 data cache.
// master = the cache controller, slave = the processor/bus environment around it.
interface coherent_dcache_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        cctrans;
  logic        ccwrite;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;

  modport master (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
    output dhit, dmemload, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

  modport slave (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccinv, ccsnoopaddr,
    input  dhit, dmemload, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );
endinterface

// File: rtl/coherent_dcache.sv
// Direct-mapped write-back MSI L1 data cache, two-word blocks; hits complete combinationally,
// misses take one cycle per bus beat plus one; every bus beat stalls while dwait is high.
module coherent_dcache #(
  parameter int SETS  = 8,
  parameter int CPUID = 0
) (
  input logic             CLK,
  input logic             nRST,
  coherent_dcache_if.master bus
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, ALLOC0, ALLOC1, SNP, SNPWB0, SNPWB1
  } state_t;

  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2} msi_t;

  state_t          state;
  msi_t            msi   [SETS];
  logic [TW-1:0]   tags  [SETS];
  logic [31:0]     word0 [SETS];
  logic [31:0]     word1 [SETS];

  logic [TW-1:0]   snp_tag;
  logic [IW-1:0]   snp_idx;
  logic            snp_inv;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic            req_off;
  logic [TW-1:0]   sa_tag;
  logic [IW-1:0]   sa_idx;

  assign req_tag = bus.dmemaddr[31:3+IW];
  assign req_idx = bus.dmemaddr[2+IW:3];
  assign req_off = bus.dmemaddr[2];
  assign sa_tag  = bus.ccsnoopaddr[31:3+IW];
  assign sa_idx  = bus.ccsnoopaddr[2+IW:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dmemaddr[1:0], bus.ccsnoopaddr[2:0]};

  logic req_match, ld_hit, st_hit, hit, miss;
  logic live_m, snp_m, snp_s;

  assign req_match = (tags[req_idx] == req_tag);
  assign ld_hit    = (msi[req_idx] != ST_I) && req_match;
  assign st_hit    = (msi[req_idx] == ST_M) && req_match;
  // A pending snoop takes the IDLE cycle, so the processor neither hits nor commits.
  assign hit       = (state == IDLE) && !bus.ccwait &&
                     ((bus.dmemREN && ld_hit) || (bus.dmemWEN && st_hit));
  assign miss      = (state == IDLE) && !bus.ccwait &&
                     (bus.dmemREN || bus.dmemWEN) && !hit;

  assign live_m = (msi[sa_idx] == ST_M) && (tags[sa_idx] == sa_tag);
  assign snp_m  = (msi[snp_idx] == ST_M) && (tags[snp_idx] == snp_tag);
  assign snp_s  = (msi[snp_idx] == ST_S) && (tags[snp_idx] == snp_tag);

  always_comb begin
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.cctrans  = 1'b0;
    bus.ccwrite  = 1'b0;
    unique case (state)
      IDLE, SNP: begin
        bus.dhit    = hit;
        if (hit && bus.dmemREN)
          bus.dmemload = req_off ? word1[req_idx] : word0[req_idx];
        bus.ccwrite = bus.ccwait && live_m;
      end
      WB0, WB1: begin
        bus.cctrans = 1'b1;
        bus.dWEN    = 1'b1;
        bus.daddr   = {tags[req_idx], req_idx, (state == WB1), 2'b00};
        bus.dstore  = (state == WB1) ? word1[req_idx] : word0[req_idx];
      end
      ALLOC0, ALLOC1: begin
        bus.cctrans = 1'b1;
        bus.dREN    = 1'b1;
        bus.ccwrite = bus.dmemWEN;
        bus.daddr   = {req_tag, req_idx, (state == ALLOC1), 2'b00};
      end
      SNPWB0, SNPWB1: begin
        bus.ccwrite = 1'b1;
        bus.daddr   = {snp_tag, snp_idx, (state == SNPWB1), 2'b00};
        bus.dstore  = (state == SNPWB1) ? word1[snp_idx] : word0[snp_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      snp_tag <= '0;
      snp_idx <= '0;
      snp_inv <= 1'b0;
      for (int i = 0; i < SETS; i++) begin
        msi[i]   <= ST_I;
        tags[i]  <= '0;
        word0[i] <= '0;
        word1[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ccwait) begin
            snp_tag <= sa_tag;
            snp_idx <= sa_idx;
            snp_inv <= bus.ccinv;
            state   <= SNP;
          end else if (bus.dmemWEN && st_hit) begin
            if (req_off) word1[req_idx] <= bus.dmemstore;
            else         word0[req_idx] <= bus.dmemstore;
          end else if (miss) begin
            state <= (msi[req_idx] == ST_M) ? WB0 : ALLOC0;
          end
        end
        WB0:    if (!bus.dwait) state <= WB1;
        WB1:    if (!bus.dwait) state <= ALLOC0;
        ALLOC0: if (!bus.dwait) begin
          // The frame is invalid until the second word and the new tag land together.
          word0[req_idx] <= bus.dload;
          msi[req_idx]   <= ST_I;
          state          <= ALLOC1;
        end
        ALLOC1: if (!bus.dwait) begin
          word1[req_idx] <= bus.dload;
          tags[req_idx]  <= req_tag;
          msi[req_idx]   <= bus.dmemWEN ? ST_M : ST_S;
          state          <= IDLE;
        end
        SNP: begin
          if (snp_m) begin
            state <= SNPWB0;
          end else begin
            if (snp_s && snp_inv) msi[snp_idx] <= ST_I;
            state <= IDLE;
          end
        end
        SNPWB0: if (!bus.dwait) state <= SNPWB1;
        SNPWB1: if (!bus.dwait) begin
          msi[snp_idx] <= snp_inv ? ST_I : ST_S;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_ld_st: assert property (@(posedge CLK) disable iff (!nRST)
                               !(bus.dmemREN && bus.dmemWEN))
    else $error("dcache %0d: load and store requested together", CPUID);

  a_snoop_quiet: assert property (@(posedge CLK) disable iff (!nRST)
                                  (state inside {SNP, SNPWB0, SNPWB1}) |-> !(bus.dREN || bus.dWEN))
    else $error("dcache %0d: bus request issued while servicing a snoop", CPUID);

endmodule

// File: tb/tb_coherent_dcache.sv
// Directed bench for coherent_dcache: a bus/memory model answers beats, a monitor
// checks hits and bus beats against expectation queues filled by the stimulus.
module tb_coherent_dcache;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  coherent_dcache_if bus ();

  coherent_dcache #(.SETS(8), .CPUID(0)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  typedef struct { logic [31:0] a; logic c; } rd_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit ld; logic [31:0] d; } hit_t;

  rd_t  exp_rd [$];
  wr_t  exp_wr [$];
  hit_t exp_hit [$];

  logic [31:0] mem [logic [31:0]];
  int total = 0;
  int bad   = 0;
  int nwait = 0;
  int wcnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input logic [31:0] a);
    total++;
    bad++;
    $display("FAIL %s: got event at %h want none", nm, a);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push_rd(input logic [31:0] a, input logic c);
    rd_t r; r.a = a; r.c = c; exp_rd.push_back(r);
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w; w.a = a; w.d = d; exp_wr.push_back(w);
  endtask
  task automatic push_hit(input bit ld, input logic [31:0] d);
    hit_t h; h.ld = ld; h.d = d; exp_hit.push_back(h);
  endtask

  // Bus and memory: one beat completes after nwait stall cycles.
  always begin
    @(negedge CLK); #1;
    if (!nRST) begin
      bus.dwait = 1'b1; wcnt = 0;
    end else if (bus.dREN || bus.dWEN || (bus.ccwrite && !bus.ccwait)) begin
      bus.dload = mem_rd(bus.daddr);
      if (wcnt >= nwait) begin
        bus.dwait = 1'b0; wcnt = 0;
        if (!bus.dREN) mem[bus.daddr] = bus.dstore;
      end else begin
        bus.dwait = 1'b1; wcnt++;
      end
    end else begin
      bus.dwait = 1'b1; wcnt = 0;
    end
  end

  hit_t hq;
  rd_t  rq;
  wr_t  wq;
  always begin
    @(negedge CLK); #2;
    if (nRST) begin
      if (bus.dhit) begin
        if (exp_hit.size() == 0) fail_evt("unexpected_dhit", bus.dmemaddr);
        else begin
          hq = exp_hit.pop_front();
          if (hq.ld) chk("load_data", bus.dmemload, hq.d);
        end
      end
      if (!bus.dwait && bus.dREN) begin
        if (exp_rd.size() == 0) fail_evt("unexpected_read", bus.daddr);
        else begin
          rq = exp_rd.pop_front();
          chk("rd_addr", bus.daddr, rq.a);
          chk("rd_ccwrite", bus.ccwrite, rq.c);
          chk("rd_cctrans", bus.cctrans, 1);
        end
      end
      if (!bus.dwait && bus.dWEN) begin
        if (exp_wr.size() == 0) fail_evt("unexpected_wb", bus.daddr);
        else begin
          wq = exp_wr.pop_front();
          chk("wb_addr", bus.daddr, wq.a);
          chk("wb_data", bus.dstore, wq.d);
          chk("wb_cctrans", bus.cctrans, 1);
        end
      end
      if (!bus.dwait && bus.ccwrite && !bus.ccwait && !bus.dREN && !bus.dWEN) begin
        if (exp_wr.size() == 0) fail_evt("unexpected_snoop_wb", bus.daddr);
        else begin
          wq = exp_wr.pop_front();
          chk("snp_addr", bus.daddr, wq.a);
          chk("snp_data", bus.dstore, wq.d);
          chk("snp_cctrans", bus.cctrans, 0);
        end
      end
    end
  end

  task automatic wait_hit(input string nm, input int exp_lat);
    int cnt = 0;
    forever begin
      #3;
      if (bus.dhit) break;
      cnt++;
      if (cnt > 200) break;
      @(negedge CLK);
    end
    if (cnt > 200) fail_evt({nm, "_timeout"}, bus.dmemaddr);
    else chk({nm, "_latency"}, cnt, exp_lat);
    @(negedge CLK);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int exp_lat);
    @(negedge CLK);
    bus.dmemREN = !wr; bus.dmemWEN = wr; bus.dmemaddr = a; bus.dmemstore = d;
    wait_hit(wr ? "store" : "load", exp_lat);
  endtask

  task automatic snoop(input logic [31:0] a, input logic inv, input logic exp_ccw);
    @(negedge CLK);
    bus.ccwait = 1'b1; bus.ccsnoopaddr = a; bus.ccinv = inv;
    #3 chk("snoop_ccwrite", bus.ccwrite, exp_ccw);
    @(negedge CLK);
    bus.ccwait = 1'b0;
    bus.ccinv  = !inv;   // must be ignored after entry
    for (int i = 0; i < 100 && exp_wr.size() != 0; i++) @(negedge CLK);
    chk("snoop_drain", exp_wr.size(), 0);
    repeat (2) @(negedge CLK);
    bus.ccinv = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {bus.dhit, bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite}, 0);
    chk({nm, "_daddr"}, bus.daddr, 0);
    chk({nm, "_dstore"}, bus.dstore, 0);
    chk({nm, "_dmemload"}, bus.dmemload, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
    bus.dload = 0; bus.dwait = 1; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
    mem[32'h40]  = 32'hAAAA_0001; mem[32'h44]  = 32'hAAAA_0002;
    mem[32'h440] = 32'hBBBB_0001; mem[32'h444] = 32'hBBBB_0002;
    #3 chk_zero("reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Cold read, zero-wait bus: two beats plus one.
    push_rd(32'h40, 0); push_rd(32'h44, 0); push_hit(1, 32'hAAAA_0001);
    req(0, 32'h40, 0, 3);
    nwait = 1;

    // Store to shared frame refetches exclusively.
    push_rd(32'h40, 1); push_rd(32'h44, 1); push_hit(0, 0);
    req(1, 32'h44, 32'h1234_5678, 5);
    push_hit(1, 32'h1234_5678);
    req(0, 32'h44, 0, 0);

    // Dirty eviction by a conflicting load.
    push_wr(32'h40, 32'hAAAA_0001); push_wr(32'h44, 32'h1234_5678);
    push_rd(32'h440, 0); push_rd(32'h444, 0); push_hit(1, 32'hBBBB_0001);
    req(0, 32'h440, 0, 9);

    // Make 0x40 dirty, then snoop it with invalidate.
    push_rd(32'h40, 1); push_rd(32'h44, 1); push_hit(0, 0);
    req(1, 32'h40, 32'hCAFE_0000, 5);
    push_wr(32'h40, 32'hCAFE_0000); push_wr(32'h44, 32'h1234_5678);
    snoop(32'h40, 1, 1);
    push_rd(32'h40, 0); push_rd(32'h44, 0); push_hit(1, 32'hCAFE_0000);
    req(0, 32'h40, 0, 5);

    // Snoop shared without invalidate, then a snoop miss: frame stays valid.
    snoop(32'h40, 0, 0);
    push_hit(1, 32'h1234_5678);
    req(0, 32'h44, 0, 0);
    snoop(32'h440, 1, 0);
    push_hit(1, 32'hCAFE_0000);
    req(0, 32'h40, 0, 0);

    // Snoop modified without invalidate downgrades to shared.
    push_rd(32'h40, 1); push_rd(32'h44, 1); push_hit(0, 0);
    req(1, 32'h44, 32'hDEAD_0001, 5);
    push_wr(32'h40, 32'hCAFE_0000); push_wr(32'h44, 32'hDEAD_0001);
    snoop(32'h40, 0, 1);
    push_hit(1, 32'hDEAD_0001);
    req(0, 32'h44, 0, 0);

    // Snoop and load hit in the same cycle: snoop first.
    push_hit(1, 32'hCAFE_0000);
    @(negedge CLK);
    bus.dmemREN = 1; bus.dmemaddr = 32'h40;
    bus.ccwait = 1; bus.ccsnoopaddr = 32'h40; bus.ccinv = 0;
    #3 chk("snoop_prio_dhit", bus.dhit, 0);
    chk("snoop_prio_ccwrite", bus.ccwrite, 0);
    @(negedge CLK);
    bus.ccwait = 0;
    wait_hit("snoop_prio", 1);

    // Snoop shared with invalidate: next load misses.
    snoop(32'h40, 1, 0);
    push_rd(32'h40, 0); push_rd(32'h44, 0); push_hit(1, 32'hCAFE_0000);
    req(0, 32'h40, 0, 5);

    // Reset in the middle of a fill.
    push_rd(32'h440, 0);
    @(negedge CLK);
    bus.dmemREN = 1; bus.dmemaddr = 32'h440;
    for (int i = 0; i < 50; i++) begin
      #3;
      if (bus.dREN && bus.daddr == 32'h444) break;
      @(negedge CLK);
    end
    chk("reach_alloc1", {bus.dREN, bus.daddr}, {1'b1, 32'h444});
    nRST = 1'b0; bus.dmemREN = 0;
    #1 chk_zero("midreset");
    @(negedge CLK);
    nRST = 1'b1;
    push_rd(32'h440, 0); push_rd(32'h444, 0); push_hit(1, 32'hBBBB_0001);
    req(0, 32'h440, 0, 5);

    repeat (3) @(negedge CLK);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_wr", exp_wr.size(), 0);
    chk("left_hit", exp_hit.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
